// File: rtl/svm_eval_pkg.sv
// Shared types and helpers for the printed-SVM evaluation sequencer.
package svm_eval_pkg;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESULT} state_t;

   localparam int CLASS_W = 3;
   typedef logic [CLASS_W-1:0] class_t;

   // Wide enough to hold every value 0..timeout_cycles.
   function automatic int wait_cnt_width(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones; clear takes priority over inc.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/svm_eval_sequencer.sv
// Feeds labelled samples to a sequential classifier one at a time, scores each
// prediction against its label and keeps running accuracy statistics.
module svm_eval_sequencer
   import svm_eval_pkg::*;
#(
   parameter int N_FEATURES     = 33,
   parameter int INPUT_WIDTH    = 4,
   parameter int N_CLASSES      = 6,
   parameter int CLASS_WIDTH    = 3,
   parameter int COUNT_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [N_FEATURES*INPUT_WIDTH-1:0] s_sample,
   input  logic [CLASS_WIDTH-1:0]            s_label,
   output logic [N_FEATURES*INPUT_WIDTH-1:0] clf_in,
   output logic                              clf_rst_n,
   input  logic                              clf_ready,
   input  logic [CLASS_WIDTH-1:0]            clf_class,
   output logic                              r_valid,
   input  logic                              r_ready,
   output logic [CLASS_WIDTH-1:0]            r_pred,
   output logic [CLASS_WIDTH-1:0]            r_label,
   output logic                              r_match,
   output logic                              r_timeout,
   input  logic                              clear,
   output logic [COUNT_WIDTH-1:0]            total_cnt,
   output logic [COUNT_WIDTH-1:0]            correct_cnt,
   output logic [COUNT_WIDTH-1:0]            timeout_cnt,
   output logic                              busy
);

   localparam int             WCW       = wait_cnt_width(TIMEOUT_CYCLES);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

   if (CLASS_WIDTH < $clog2(N_CLASSES)) begin : g_cfg_check
      $error("CLASS_WIDTH too narrow for N_CLASSES");
   end

   state_t                 state_q, state_d;
   logic [WCW-1:0]         wait_cnt;
   logic [CLASS_WIDTH-1:0] label_q;
   logic                   clf_ready_q;
   logic                   accept, rise, expired, hit, done;

   // Both streams transfer on a cycle where valid and ready are high together;
   // valid never drops and payload never changes until that transfer.
   assign s_ready = (state_q == IDLE);
   assign busy    = (state_q != IDLE);
   assign accept  = s_valid && s_ready;
   assign rise    = clf_ready && !clf_ready_q;
   assign expired = (wait_cnt == WAIT_LAST);
   assign hit     = (clf_class == label_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         IDLE:    if (accept) state_d = LAUNCH;
         LAUNCH:  state_d = WAIT;
         WAIT: begin
            // A ready edge on the last allowed cycle still counts as a result.
            if (rise || expired) begin
               state_d = RESULT;
               done    = 1'b1;
            end
         end
         RESULT:  if (r_valid && r_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clf_in      <= '0;
         label_q     <= '0;
         clf_rst_n   <= 1'b0;
         clf_ready_q <= 1'b0;
         wait_cnt    <= '0;
         r_valid     <= 1'b0;
         r_pred      <= '0;
         r_label     <= '0;
         r_match     <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         clf_ready_q <= clf_ready;
         clf_rst_n   <= (state_d != LAUNCH);
         r_valid     <= (state_d == RESULT);
         if (accept) begin
            clf_in  <= s_sample;
            label_q <= s_label;
         end
         if (state_q == LAUNCH)    wait_cnt <= '0;
         else if (state_q == WAIT) wait_cnt <= wait_cnt + WCW'(1);
         if (done) begin
            r_label <= label_q;
            if (rise) begin
               r_pred    <= clf_class;
               r_match   <= hit;
               r_timeout <= 1'b0;
            end else begin
               r_pred    <= '0;
               r_match   <= 1'b0;
               r_timeout <= 1'b1;
            end
         end
      end
   end

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_total (
      .clk(clk), .rst_n(rst_n), .clear(clear), .inc(done), .count(total_cnt)
   );

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_correct (
      .clk(clk), .rst_n(rst_n), .clear(clear), .inc(done && rise && hit), .count(correct_cnt)
   );

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_timeout (
      .clk(clk), .rst_n(rst_n), .clear(clear), .inc(done && !rise), .count(timeout_cnt)
   );

endmodule

// File: tb/tb_svm_eval_sequencer.sv
// Directed bench for svm_eval_sequencer with a behavioural classifier model
// and a queue-based result scoreboard.
module tb_svm_eval_sequencer;

   localparam int SW = 33 * 4;
   localparam int CW = 3;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [SW-1:0] s_sample;
   logic [CW-1:0] s_label;
   logic [SW-1:0] clf_in;
   logic          clf_rst_n;
   logic          clf_ready = 1'b0;
   logic [CW-1:0] clf_class;
   logic          r_valid;
   logic          r_ready;
   logic [CW-1:0] r_pred;
   logic [CW-1:0] r_label;
   logic          r_match;
   logic          r_timeout;
   logic          clear;
   logic [NW-1:0] total_cnt;
   logic [NW-1:0] correct_cnt;
   logic [NW-1:0] timeout_cnt;
   logic          busy;

   svm_eval_sequencer #(
      .N_FEATURES(33), .INPUT_WIDTH(4), .N_CLASSES(6), .CLASS_WIDTH(CW),
      .COUNT_WIDTH(NW), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_sample(s_sample), .s_label(s_label), .clf_in(clf_in), .clf_rst_n(clf_rst_n),
      .clf_ready(clf_ready), .clf_class(clf_class), .r_valid(r_valid), .r_ready(r_ready),
      .r_pred(r_pred), .r_label(r_label), .r_match(r_match), .r_timeout(r_timeout),
      .clear(clear), .total_cnt(total_cnt), .correct_cnt(correct_cnt),
      .timeout_cnt(timeout_cnt), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // classifier model: raises ready m_delay cycles after its reset releases (0 = never)
   int            m_delay = 0;
   int            m_cnt   = 0;
   logic [CW-1:0] m_class = '0;
   assign clf_class = m_class;

   always @(negedge clk) begin
      if (!clf_rst_n) begin
         m_cnt     = 0;
         clf_ready = 1'b0;
      end else if (m_delay != 0 && m_cnt < m_delay) begin
         m_cnt++;
         if (m_cnt == m_delay) clf_ready = 1'b1;
      end
   end

   // scoreboard: {latency[7:0], pred, label, match, timeout}
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   int          acc_q[$];

   task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor
   logic        prev_rv = 1'b0;
   int          seen_lat = -1;
   logic [15:0] e;

   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (r_valid && !prev_rv) begin
            if (acc_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               seen_lat = cyc - acc_q.pop_front();
            end
         end
         if (r_valid && r_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_handshake", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("latency",   seen_lat,  int'(e[15:8]));
               check("r_pred",    r_pred,    e[7:5]);
               check("r_label",   r_label,   e[4:2]);
               check("r_match",   r_match,   e[1]);
               check("r_timeout", r_timeout, e[0]);
            end
         end
      end
      prev_rv = r_valid;
   end

   // driver tasks
   task automatic send(input logic [SW-1:0] smp, input logic [CW-1:0] lbl, input int dly,
                       input logic [CW-1:0] cls, input bit push, input logic [CW-1:0] e_pred,
                       input bit e_match, input bit e_to, input int e_lat);
      int n = 0;
      m_delay  = dly;
      m_class  = cls;
      s_sample = smp;
      s_label  = lbl;
      s_valid  = 1'b1;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         check("accept_timeout", 1, 0);
         s_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      if (push) begin
         acc_q.push_back(cyc);
         exp_q.push_back({8'(e_lat), e_pred, lbl, e_match, e_to});
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      check("idle_timeout", 1, 0);
   endtask

   task automatic check_cnt(input string tag, input int t, input int c, input int o);
      check({tag, "_total"},   total_cnt,   t);
      check({tag, "_correct"}, correct_cnt, c);
      check({tag, "_timeout"}, timeout_cnt, o);
   endtask

   logic [SW-1:0] smp_a, smp_c, smp_e, smp_f;

   initial begin
      smp_a    = {33{4'h5}};
      smp_c    = {11{12'h3C9}};
      smp_e    = {33{4'hA}};
      smp_f    = {11{12'h17E}};
      rst_n    = 1'b0;
      s_valid  = 1'b0;
      s_sample = '0;
      s_label  = '0;
      r_ready  = 1'b1;
      clear    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_s_ready", s_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_clf_rst_n", clf_rst_n, 0);
      check("rst_r_valid", r_valid, 0);
      check("rst_clf_in", clf_in, 0);
      check_cnt("rst", 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_s_ready", s_ready, 1);
      check("rel_clf_rst_n", clf_rst_n, 1);

      // matching prediction after 18 cycles
      send(smp_a, 3'd3, 18, 3'd3, 1, 3'd3, 1, 0, 19);
      wait_idle();
      check_cnt("a", 1, 1, 0);

      // mismatch
      send(smp_a, 3'd2, 10, 3'd5, 1, 3'd5, 0, 0, 11);
      wait_idle();
      check_cnt("b", 2, 1, 0);

      // classifier never answers: 1-cycle classifier reset, then timeout
      send(smp_c, 3'd4, 0, 3'd6, 1, 3'd0, 0, 1, 65);
      check("launch_clf_rst_n", clf_rst_n, 0);
      check("launch_clf_in", clf_in, smp_c);
      @(negedge clk);
      check("wait_clf_rst_n", clf_rst_n, 1);
      check("wait_busy", busy, 1);
      wait_idle();
      check_cnt("c", 3, 1, 1);
      check("idle_clf_in", clf_in, smp_c);

      // ready edge on the last allowed wait cycle
      send(smp_a, 3'd1, 64, 3'd1, 1, 3'd1, 1, 0, 65);
      wait_idle();
      check_cnt("d", 4, 2, 1);

      // consumer stalls for 5 cycles while the next sample waits
      r_ready = 1'b0;
      send(smp_e, 3'd2, 3, 3'd2, 1, 3'd2, 1, 0, 4);
      for (int i = 0; i < 100 && !r_valid; i++) @(negedge clk);
      check("stall_r_valid", r_valid, 1);
      s_sample = smp_f;
      s_label  = 3'd0;
      s_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_r_pred", r_pred, 3'd2);
         check("stall_r_label", r_label, 3'd2);
         check("stall_r_match", r_match, 1);
         check("stall_s_ready", s_ready, 0);
         check("stall_clf_in", clf_in, smp_e);
      end
      r_ready = 1'b1;
      @(negedge clk);
      check("post_hs_s_ready", s_ready, 1);
      check("post_hs_busy", busy, 0);
      send(smp_f, 3'd0, 5, 3'd0, 1, 3'd0, 1, 0, 6);
      check("f_accepted_clf_in", clf_in, smp_f);
      wait_idle();
      check_cnt("f", 6, 4, 1);

      // saturation and clear priority
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_cnt("clear", 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         send(smp_a, 3'd1, 2, 3'd1, 1, 3'd1, 1, 0, 3);
         wait_idle();
      end
      check_cnt("sat", 15, 15, 0);
      send(smp_a, 3'd1, 2, 3'd1, 1, 3'd1, 1, 0, 3);
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_inc_r_valid", r_valid, 1);
      check_cnt("clr_inc", 0, 0, 0);
      wait_idle();

      // reset during WAIT
      send(smp_c, 3'd5, 4, 3'd2, 1, 3'd2, 0, 0, 5);
      wait_idle();
      check_cnt("g", 1, 0, 0);
      send(smp_e, 3'd3, 30, 3'd3, 0, 3'd0, 0, 0, 0);
      repeat (5) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_clf_rst_n", clf_rst_n, 0);
      check("mid_rst_r_valid", r_valid, 0);
      check("mid_rst_busy", busy, 0);
      check_cnt("mid_rst", 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_s_ready", s_ready, 1);
      check("post_rst_clf_rst_n", clf_rst_n, 1);
      send(smp_f, 3'd4, 7, 3'd4, 1, 3'd4, 1, 0, 8);
      wait_idle();
      check_cnt("i", 1, 1, 0);

      repeat (3) @(negedge clk);
      check("exp_q_empty", exp_q.size(), 0);
      check("acc_q_empty", acc_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/svm_eval_sequencer.md
Name: svm_eval_sequencer

Overview:
Synthesizable sample sequencer and accuracy monitor for the sequential printed-SVM classifier tops.
- Accepts labelled samples on a valid/ready stream.
- Restarts the classifier per sample, waits for its ready rising edge (with a timeout watchdog), and compares predicted vs. true class.
- Emits a result stream and keeps saturating total/correct/timeout counters.
- Sits between the stimulus source (ROM/UART/bench) and any classifier top with the in/ready/w_class contract.

Parameters:
- N_FEATURES, 33, features per sample.
- INPUT_WIDTH, 4, bits per feature.
- N_CLASSES, 6, number of classes.
- CLASS_WIDTH, 3, class index width; must be ≥ $clog2(N_CLASSES).
- COUNT_WIDTH, 16, width of each statistics counter.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the sample is declared timed out; range 1..2^16-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  sample available.
- s_ready  out  1  sequencer can accept a sample.
- s_sample  in  N_FEATURES*INPUT_WIDTH  packed features, feature 0 in the LSBs.
- s_label  in  CLASS_WIDTH  true class.
- clf_in  out  N_FEATURES*INPUT_WIDTH  registered sample driven to the classifier.
- clf_rst_n  out  1  classifier per-sample reset, active low.
- clf_ready  in  1  classifier done flag.
- clf_class  in  CLASS_WIDTH  classifier prediction.
- r_valid  out  1  result available.
- r_ready  in  1  result consumer ready.
- r_pred  out  CLASS_WIDTH  captured prediction; 0 on timeout.
- r_label  out  CLASS_WIDTH  label of this sample.
- r_match  out  1  r_pred==r_label and no timeout.
- r_timeout  out  1  watchdog expired.
- clear  in  1  synchronous clear of all counters.
- total_cnt  out  COUNT_WIDTH  samples completed.
- correct_cnt  out  COUNT_WIDTH  matches.
- timeout_cnt  out  COUNT_WIDTH  timeouts.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state=IDLE. All of the following are 0: clf_rst_n, clf_in, r_*, counters, busy, the wait counter, and clf_ready_q. s_ready is 1 after reset release.
- Outputs are registered, except:
  - s_ready = (state==IDLE);
  - busy = (state!=IDLE).
- clf_ready_q <= clf_ready every cycle. Rising edge = clf_ready & ~clf_ready_q.
- IDLE:
  - clf_rst_n=1.
  - On s_valid&s_ready: latch s_sample into clf_in and s_label into a label register; go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - clf_rst_n=0; wait counter cleared; go to WAIT.
- WAIT:
  - clf_rst_n=1; wait counter increments each cycle.
  - On a rising edge: r_pred<=clf_class, r_match<=(clf_class==label), r_timeout<=0; go to RESULT.
  - Otherwise, if wait counter == TIMEOUT_CYCLES-1: r_pred<=0, r_match<=0, r_timeout<=1; go to RESULT.
  - Edge and timeout in the same cycle: the edge wins.
- RESULT:
  - r_valid=1. r_pred, r_label, r_match and r_timeout stay stable until r_valid&r_ready.
  - On r_valid&r_ready: go to IDLE, r_valid<=0.
  - A new sample can be accepted at the earliest in the cycle after the handshake.
- Latency:
  - Accept at cycle T → clf_rst_n low in T+1 → WAIT from T+2.
  - Edge sampled at clock k → r_valid high from k+1.
- clf_in is held stable from accept until the next accept, including during RESULT/IDLE.
- Counters:
  - Updated on the WAIT→RESULT transition: total+1; correct+1 if match; timeout+1 if timeout.
  - All saturate at 2^COUNT_WIDTH-1 (no wrap).
  - clear: all counters ← 0 next cycle. Clear and increment in the same cycle → 0 (clear wins). Clear has no effect on state or the result stream.
- Reset mid-operation from any state: immediate return to reset values. clf_rst_n goes low asynchronously, so the classifier is also held in reset.
- A rising edge of clf_ready outside WAIT is ignored.

Decomposition:
- Package svm_eval_pkg:
  - state enum {IDLE, LAUNCH, WAIT, RESULT} (2-bit);
  - localparam function for the wait counter width, $clog2(TIMEOUT_CYCLES+1);
  - shared class-index typedef.
- Sub-module sat_counter (parameter WIDTH; inputs clk, rst_n, clear, inc; output count). Instantiated three times.

Test Plan:
- Classifier model returns class 3 after 18 cycles; sample label 3 → r_valid one cycle after the ready edge, r_pred=3, r_match=1, r_timeout=0, total=1, correct=1.
- Label 2, model returns 5 → r_match=0, total=1, correct=0; then clf_rst_n is low exactly 1 cycle after the next accept.
- Model never raises ready, TIMEOUT_CYCLES=64 → r_timeout=1 after 64 WAIT cycles, r_pred=0, timeout_cnt=1. Ready edge on exactly the 64th cycle → normal result, timeout_cnt unchanged.
- r_ready held low 5 cycles in RESULT → r_* stable, s_ready=0, s_valid stalled; accepted in the cycle after the handshake.
- COUNT_WIDTH=4, 17 matching samples → total_cnt=15, correct_cnt=15. clear asserted together with the 17th increment → both 0.
- rst_n asserted during WAIT → same-cycle clf_rst_n=0, r_valid=0, counters 0. After release, s_ready=1 and the next sample proceeds normally.
